led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of LED channels; legal range 1..6.
REQ-002 SHALL have parameter PWM_BITS, default 8, meaning width of the PWM counter, duty registers and breathe level; legal range 4..8.
REQ-003 SHALL have port xclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_stb, input, 1 bit: single-cycle register write strobe.
REQ-006 SHALL have port wr_addr, input, 4 bits: write register address.
REQ-007 SHALL have port wr_data, input, 8 bits: write data.
REQ-008 SHALL have port rd_addr, input, 4 bits: read register address.
REQ-009 SHALL have port rd_data, output, 8 bits: registered read data.
REQ-010 SHALL have port led, output, NUM_CH bits: registered LED drive, 1 = lit.

Function
REQ-011 SHALL implement this register map:
- 0 GCTRL: bit0 EN, other bits read 0.
- 1 DIV_LO; 2 DIV_HI: 16-bit tick divisor DIV.
- 3 BLINK_LEN: ticks per blink half-period, minus 1.
- 4+2*i MODE[i]: bits 2:0.
- 5+2*i DUTY[i]: bits PWM_BITS-1:0, upper bits read 0.
REQ-012 SHALL ignore writes to unmapped addresses, and SHALL return 0 on reads of them.
REQ-013 SHALL update a register at the rising edge where wr_stb=1; rd_data SHALL equal register[rd_addr] one cycle after rd_addr is presented.
REQ-014 SHALL run a free-running PWM counter pwm_cnt, PWM_BITS wide, wrapping from all-ones to 0, independent of EN.
REQ-015 SHALL run a prescaler counting 0..DIV and pulse tick for one cycle when count==DIV, then reload 0; DIV=0 SHALL give tick every cycle.
REQ-016 SHALL, on a write to DIV_LO or DIV_HI, clear the prescaler and suppress tick in that cycle.
REQ-017 SHALL run a blink counter counting ticks 0..BLINK_LEN; on the tick where it equals BLINK_LEN it SHALL reload 0 and toggle phase.
REQ-018 SHALL run a breathe level and direction flag dir (up/down); each tick moves level by 1, with this triangle behaviour:
- level reaching all-ones SHALL set dir=down;
- level reaching 0 SHALL set dir=up;
- the endpoints SHALL NOT be repeated.
REQ-019 SHALL, while EN=0, hold the prescaler, blink counter, phase, level and dir at reset values and drive led=0.
REQ-020 SHALL define the per-channel PWM gate as pwm_on[i] = (pwm_cnt < DUTY[i]); DUTY=0 is never on, and all-ones is off for one cycle per PWM period.
REQ-021 SHALL compute the next led[i] by MODE[i]:
- 0 OFF: 0.
- 1 ON: pwm_on[i].
- 2 BLINK: phase AND pwm_on[i].
- 3 ALTERNATE: (phase XOR i[0]) AND pwm_on[i].
- 4 BREATHE: pwm_cnt < level.
- 5 SYNC: the next led[0].
- 6, 7: 0.
REQ-022 SHALL treat SYNC on channel 0 as OFF.
REQ-023 SHALL register led, so that a configuration write is visible on led at the second rising edge after wr_stb is sampled.
REQ-024 SHALL apply a MODE or DUTY change without disturbing the shared counters.

Reset
REQ-025 SHALL, when sys_rst asserts, immediately and without waiting for xclk clear all of the following:
- every register;
- pwm_cnt, prescaler, blink counter;
- phase=0, level=0, dir=up;
- led=0, rd_data=0.
REQ-026 SHALL, on sys_rst mid-operation, abandon all pattern state; after release, operation restarts with EN=0.

Verification
REQ-027 SHALL cover: EN=1, MODE[0]=1, DUTY[0]=0x80 -> led[0] high for exactly 128 of every 256 cycles, aligned with pwm_cnt 0..127.
REQ-028 SHALL cover: DIV=0, BLINK_LEN=3, MODE[0]=2, DUTY[0]=0xFF -> phase toggles every 4 cycles; led[0] 0 for 4 cycles, then lit 4 cycles except when pwm_cnt=0xFF.
REQ-029 SHALL cover: both channels MODE=3, DUTY=0xFF -> led[0] and led[1] never simultaneously 1; each swaps on every phase toggle.
REQ-030 SHALL cover: MODE[0]=4, DIV=0 -> level runs 0..255 then 254..0; period 510 ticks; no repeated endpoint values.
REQ-031 SHALL cover: MODE[0]=2, MODE[1]=5 -> led[1]==led[0] every cycle; MODE[0]=5 -> led[0]=0.
REQ-032 SHALL cover: sys_rst asserted mid-blink and between clock edges -> led=0 and rd_data=0 before the next xclk edge; all registers read 0 after release.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: register file, shared PWM/tick/blink/breathe timebase,
// and one mode selector per channel feeding a registered LED output.

module led_chan #(
  parameter int PWM_BITS = 8,
  parameter bit ALT      = 1'b0
) (
  input  logic [2:0]          i_mode,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic [PWM_BITS-1:0] i_pwm,
  input  logic [PWM_BITS-1:0] i_level,
  input  logic                i_phase,
  input  logic                i_sync,
  output logic                o_led_nxt
);
  logic w_on;

  always_comb begin
    w_on      = (i_pwm < i_duty);
    o_led_nxt = 1'b0;
    case (i_mode)
      3'd1:    o_led_nxt = w_on;
      3'd2:    o_led_nxt = i_phase & w_on;
      3'd3:    o_led_nxt = (i_phase ^ ALT) & w_on;
      3'd4:    o_led_nxt = (i_pwm < i_level);
      3'd5:    o_led_nxt = i_sync;
      default: o_led_nxt = 1'b0;
    endcase
  end
endmodule

module led_pattern_gen #(
  parameter int NUM_CH   = 2,
  parameter int PWM_BITS = 8
) (
  input  logic              xclk,
  input  logic              sys_rst,
  input  logic              wr_stb,
  input  logic [3:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [3:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] led
);
  localparam logic [PWM_BITS-1:0] L_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0] L_MAX = '1;
  localparam logic [PWM_BITS-1:0] L_TOP = L_MAX - L_ONE;

  logic                             r_en;
  logic [15:0]                      r_div;
  logic [7:0]                       r_blink_len;
  logic [NUM_CH-1:0][2:0]           r_mode;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  r_duty;

  logic [PWM_BITS-1:0] r_pwm, r_level;
  logic [15:0]         r_presc;
  logic [7:0]          r_bcnt;
  logic                r_phase, r_dir;

  logic [7:0]          r_rd_data, w_rd_data;
  logic [NUM_CH-1:0]   r_led, w_led_nxt;
  logic                w_led0, w_div_wr, w_tick;

  assign w_div_wr = wr_stb && (wr_addr == 4'd1 || wr_addr == 4'd2);
  assign w_tick   = r_en && !w_div_wr && (r_presc == r_div);

  // Register file writes
  always_ff @(posedge xclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_en        <= 1'b0;
      r_div       <= '0;
      r_blink_len <= '0;
      r_mode      <= '0;
      r_duty      <= '0;
    end else if (wr_stb) begin
      case (wr_addr)
        4'd0:    r_en        <= wr_data[0];
        4'd1:    r_div[7:0]  <= wr_data;
        4'd2:    r_div[15:8] <= wr_data;
        4'd3:    r_blink_len <= wr_data;
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == 4'(4 + 2*i)) r_mode[i] <= wr_data[2:0];
        if (wr_addr == 4'(5 + 2*i)) r_duty[i] <= wr_data[PWM_BITS-1:0];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (rd_addr)
      4'd0:    w_rd_data = {7'd0, r_en};
      4'd1:    w_rd_data = r_div[7:0];
      4'd2:    w_rd_data = r_div[15:8];
      4'd3:    w_rd_data = r_blink_len;
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == 4'(4 + 2*i)) w_rd_data = {5'd0, r_mode[i]};
      if (rd_addr == 4'(5 + 2*i)) w_rd_data = 8'(r_duty[i]);
    end
  end

  // Shared timebase; everything but the PWM counter idles at reset values while EN=0
  always_ff @(posedge xclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pwm   <= '0;
      r_presc <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_level <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_pwm <= r_pwm + L_ONE;
      if (!r_en) begin
        r_presc <= '0;
        r_bcnt  <= '0;
        r_phase <= 1'b0;
        r_level <= '0;
        r_dir   <= 1'b0;
      end else begin
        if (w_div_wr || r_presc == r_div) r_presc <= '0;
        else                              r_presc <= r_presc + 16'd1;
        if (w_tick) begin
          if (r_bcnt == r_blink_len) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_bcnt <= r_bcnt + 8'd1;
          end
          // Direction flips on arrival at an endpoint so it is never revisited
          if (!r_dir) begin
            r_level <= r_level + L_ONE;
            if (r_level == L_TOP) r_dir <= 1'b1;
          end else begin
            r_level <= r_level - L_ONE;
            if (r_level == L_ONE) r_dir <= 1'b0;
          end
        end
      end
    end
  end

  // Channel 0 is the SYNC source, so it is built apart to keep the path acyclic
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    if (g == 0) begin : g_lead
      led_chan #(.PWM_BITS(PWM_BITS), .ALT(1'b0)) u_chan (
        .i_mode(r_mode[g]), .i_duty(r_duty[g]), .i_pwm(r_pwm), .i_level(r_level),
        .i_phase(r_phase), .i_sync(1'b0), .o_led_nxt(w_led0)
      );
    end else begin : g_follow
      led_chan #(.PWM_BITS(PWM_BITS), .ALT(g % 2 == 1)) u_chan (
        .i_mode(r_mode[g]), .i_duty(r_duty[g]), .i_pwm(r_pwm), .i_level(r_level),
        .i_phase(r_phase), .i_sync(w_led0), .o_led_nxt(w_led_nxt[g])
      );
    end
  end
  assign w_led_nxt[0] = w_led0;

  always_ff @(posedge xclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_led     <= '0;
      r_rd_data <= '0;
    end else begin
      r_led     <= r_en ? w_led_nxt : '0;
      r_rd_data <= w_rd_data;
    end
  end

  assign led     = r_led;
  assign rd_data = r_rd_data;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: register map, PWM, blink, alternate,
// breathe, sync, prescaler reload and asynchronous reset.

module tb_led_pattern_gen;
  localparam int NUM_CH = 2;
  localparam int PWM_BITS = 8;

  logic              xclk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              wr_stb = 1'b0;
  logic [3:0]        wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic [3:0]        rd_addr = '0;
  logic [7:0]        rd_data;
  logic [NUM_CH-1:0] led;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic [7:0] tb_pwm;

  led_pattern_gen #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS)) dut (
    .xclk(xclk), .sys_rst(sys_rst), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .led(led)
  );

  always #5 xclk = ~xclk;

  // Free-running reference for the PWM counter
  always @(posedge xclk or posedge sys_rst)
    if (sys_rst) tb_pwm <= 8'd0;
    else         tb_pwm <= tb_pwm + 8'd1;

  // PWM count that the DUT saw on the most recent rising edge
  function automatic logic [7:0] pprev();
    return tb_pwm - 8'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge xclk);
    wr_stb = 1'b1; wr_addr = a; wr_data = d;
    @(negedge xclk);
    wr_stb = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] e, input string tag);
    @(negedge xclk);
    rd_addr = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge xclk);
    check(tag_q.pop_front(), 32'(rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic do_reset();
    @(negedge xclk); sys_rst = 1'b1;
    @(negedge xclk); sys_rst = 1'b0;
  endtask

  initial begin
    int hi, ph, lvl, p;
    bit on, e0;

    // Reset state and register map
    repeat (2) @(negedge xclk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    sys_rst = 1'b0;
    for (int a = 0; a < 16; a++) rd_chk(4'(a), 8'h00, "rst_reg");
    wr(4'd1, 8'h34); wr(4'd2, 8'h12); wr(4'd3, 8'h56);
    wr(4'd4, 8'hFF); wr(4'd5, 8'hAB); wr(4'd6, 8'h03);
    wr(4'd8, 8'h5A); wr(4'd15, 8'h77); wr(4'd0, 8'hFF);
    rd_chk(4'd0, 8'h01, "gctrl");
    rd_chk(4'd1, 8'h34, "div_lo");
    rd_chk(4'd2, 8'h12, "div_hi");
    rd_chk(4'd3, 8'h56, "blink_len");
    rd_chk(4'd4, 8'h07, "mode0");
    rd_chk(4'd5, 8'hAB, "duty0");
    rd_chk(4'd6, 8'h03, "mode1");
    rd_chk(4'd7, 8'h00, "duty1");
    rd_chk(4'd8, 8'h00, "unmapped8");
    rd_chk(4'd15, 8'h00, "unmapped15");
    check("mode7_led", 32'(led), 32'd0);

    // 50% duty on ch0, zero duty on ch1
    do_reset();
    wr(4'd5, 8'h80); wr(4'd4, 8'h01); wr(4'd6, 8'h01); wr(4'd0, 8'h01);
    hi = 0;
    for (int n = 1; n <= 512; n++) begin
      @(negedge xclk);
      check("pwm50", 32'(led[0]), 32'(pprev() < 8'h80));
      check("duty0", 32'(led[1]), 32'd0);
      if (n > 256 && led[0]) hi++;
    end
    check("pwm50_cnt", 32'(hi), 32'd128);

    // Blink on ch0 with ch1 in SYNC, then reset between edges
    do_reset();
    wr(4'd3, 8'h03); wr(4'd5, 8'hFF); wr(4'd4, 8'h02); wr(4'd6, 8'h05);
    rd_addr = 4'd3;
    wr(4'd0, 8'h01);
    for (int n = 1; n <= 302; n++) begin
      @(negedge xclk);
      ph = ((n - 1) / 4) % 2;
      e0 = (ph == 1) && (pprev() != 8'hFF);
      check("blink0", 32'(led[0]), 32'(e0));
      check("sync1", 32'(led[1]), 32'(e0));
    end
    check("pre_rst_rd", 32'(rd_data), 32'h03);
    #2 sys_rst = 1'b1;
    #1;
    check("async_led", 32'(led), 32'd0);
    check("async_rd", 32'(rd_data), 32'd0);
    @(negedge xclk); sys_rst = 1'b0;
    for (int a = 0; a < 8; a++) rd_chk(4'(a), 8'h00, "post_rst_reg");
    check("post_rst_led", 32'(led), 32'd0);

    // Alternate on both channels
    do_reset();
    wr(4'd3, 8'h03); wr(4'd5, 8'hFF); wr(4'd7, 8'hFF);
    wr(4'd4, 8'h03); wr(4'd6, 8'h03); wr(4'd0, 8'h01);
    for (int n = 1; n <= 300; n++) begin
      @(negedge xclk);
      ph = ((n - 1) / 4) % 2;
      on = (pprev() != 8'hFF);
      check("alt0", 32'(led[0]), 32'((ph == 1) && on));
      check("alt1", 32'(led[1]), 32'((ph == 0) && on));
      check("alt_excl", 32'(led[0] & led[1]), 32'd0);
    end

    // SYNC on channel 0 behaves as OFF
    do_reset();
    wr(4'd4, 8'h05); wr(4'd6, 8'h01); wr(4'd7, 8'hFF); wr(4'd0, 8'h01);
    for (int n = 1; n <= 40; n++) begin
      @(negedge xclk);
      check("sync_ch0", 32'(led[0]), 32'd0);
      check("on1", 32'(led[1]), 32'(pprev() != 8'hFF));
    end

    // Breathe: triangle 0..255..1, period 510 ticks
    do_reset();
    wr(4'd4, 8'h04); wr(4'd0, 8'h01);
    for (int n = 1; n <= 1100; n++) begin
      @(negedge xclk);
      p = (n - 1) % 510;
      lvl = (p <= 255) ? p : 510 - p;
      check("breathe", 32'(led[0]), 32'(int'(pprev()) < lvl));
    end

    // DIV=2 ticks every third cycle; a DIV write restarts the prescaler
    do_reset();
    wr(4'd1, 8'h02); wr(4'd3, 8'h00); wr(4'd5, 8'hFF); wr(4'd4, 8'h02); wr(4'd0, 8'h01);
    for (int n = 1; n <= 61; n++) begin
      @(negedge xclk);
      ph = ((n - 1) / 3) % 2;
      check("div2", 32'(led[0]), 32'((ph == 1) && (pprev() != 8'hFF)));
    end
    wr(4'd1, 8'h02);
    for (int n = 63; n <= 100; n++) begin
      @(negedge xclk);
      p = n - 1;
      ph = (p >= 65) ? (((p - 65) / 3) + 1) % 2 : 0;
      check("div_rewr", 32'(led[0]), 32'((ph == 1) && (pprev() != 8'hFF)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
